// File: rtl/tick_timeout_pkg.sv
// Shared types and constants for the tick_timeout engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the FSM state encoding and the tick-unit encoding used on the `unit` port.
package tick_timeout_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIRE = 2'd2
    } state_e;

    localparam logic [1:0] UNIT_USEC = 2'd0;
    localparam logic [1:0] UNIT_MSEC = 2'd1;
    localparam logic [1:0] UNIT_SEC  = 2'd2;
    localparam logic [1:0] UNIT_CLK  = 2'd3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with increment enable.
// Latency: count updates on the edge that samples inc.
// Backpressure: none; holds at all-ones once saturated.
//
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset, clears the count
//   inc  - add one this cycle (ignored once saturated)
//   cnt  - registered count value
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/tick_timeout.sv
// Programmable timeout: counts a requested number of usec/msec/sec/clk ticks, then pulses expired.
// Latency: start at edge N -> busy/remaining from N+1; unit=3, count=C -> expired in cycle N+C+1.
// Backpressure: none; start/cancel are single-cycle requests, cancel > start > tick while running.
//
// Ports:
//   clk_133m, rst            - clock, synchronous active-high reset
//   usec/msec/sec_133m       - shared single-cycle tick strobes from the board timer
//   start, unit, count       - arm request with tick source and tick count (0 = expire now)
//   cancel                   - abort a running timeout without an expiry
//   busy, expired            - counting flag, one-cycle completion pulse
//   remaining, expire_cnt    - ticks left, saturating number of expiries since reset
module tick_timeout
    import tick_timeout_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int EXP_W = 8
) (
    input  logic             clk_133m,
    input  logic             rst,
    input  logic             usec_133m,
    input  logic             msec_133m,
    input  logic             sec_133m,
    input  logic             start,
    input  logic [1:0]       unit,
    input  logic [CNT_W-1:0] count,
    input  logic             cancel,
    output logic             busy,
    output logic             expired,
    output logic [CNT_W-1:0] remaining,
    output logic [EXP_W-1:0] expire_cnt
);

    state_e           state_q,     state_d;
    logic [1:0]       unit_q,      unit_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             busy_q,      busy_d;
    logic             expired_q,   expired_d;

    logic             tick_sel;
    logic             do_load;
    logic             do_cancel;
    logic             do_tick;

    // Only the strobe matching the latched unit counts; coincident strobes of
    // other units are ignored.
    always_comb begin
        tick_sel = 1'b0;
        case (unit_q)
            UNIT_USEC: tick_sel = usec_133m;
            UNIT_MSEC: tick_sel = msec_133m;
            UNIT_SEC:  tick_sel = sec_133m;
            UNIT_CLK:  tick_sel = 1'b1;
            default:   tick_sel = 1'b0;
        endcase
    end

    // Arbitrate the requests for the current state. In RUN a start wins over a
    // coincident tick, so the reloaded count is never decremented on load.
    // cancel in IDLE and FIRE is deliberately dropped.
    always_comb begin
        do_load   = 1'b0;
        do_cancel = 1'b0;
        do_tick   = 1'b0;
        case (state_q)
            IDLE: do_load = start;
            RUN: begin
                if (cancel) begin
                    do_cancel = 1'b1;
                end else if (start) begin
                    do_load = 1'b1;
                end else begin
                    do_tick = tick_sel;
                end
            end
            FIRE:    do_load = start;
            default: do_load = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        unit_d      = unit_q;
        remaining_d = remaining_q;

        if (do_load) begin
            unit_d      = unit;
            remaining_d = count;
            state_d     = (count == '0) ? FIRE : RUN;
        end else if (do_cancel) begin
            remaining_d = '0;
            state_d     = IDLE;
        end else if (do_tick) begin
            remaining_d = remaining_q - CNT_W'(1);
            if (remaining_q == CNT_W'(1)) begin
                state_d = FIRE;
            end
        end else if (state_q != RUN) begin
            // FIRE without a new start, or an illegal encoding, falls back to IDLE.
            state_d = IDLE;
        end

        // Outputs are registered from the next state so they line up with it.
        busy_d    = (state_d == RUN);
        expired_d = (state_d == FIRE);
    end

    always_ff @(posedge clk_133m) begin
        if (rst) begin
            state_q     <= IDLE;
            unit_q      <= UNIT_USEC;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            expired_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            unit_q      <= unit_d;
            remaining_q <= remaining_d;
            busy_q      <= busy_d;
            expired_q   <= expired_d;
        end
    end

    // Incremented on the same edge that raises expired, so the count already
    // includes the expiry being pulsed.
    sat_counter #(
        .W (EXP_W)
    ) u_exp_cnt (
        .clk (clk_133m),
        .rst (rst),
        .inc (expired_d),
        .cnt (expire_cnt)
    );

    assign busy      = busy_q;
    assign expired   = expired_q;
    assign remaining = remaining_q;

endmodule

// File: tb/tb_tick_timeout.sv
module tb_tick_timeout;

    logic        clk_133m = 1'b0;
    logic        rst;
    logic        usec_133m, msec_133m, sec_133m;
    logic        start;
    logic [1:0]  unit;
    logic [15:0] count;
    logic        cancel;
    logic        busy;
    logic        expired;
    logic [15:0] remaining;
    logic [7:0]  expire_cnt;

    int test_cnt = 0;
    int fail_cnt = 0;

    always #4 clk_133m = ~clk_133m;

    tick_timeout #(.CNT_W(16), .EXP_W(8)) dut (
        .clk_133m   (clk_133m),
        .rst        (rst),
        .usec_133m  (usec_133m),
        .msec_133m  (msec_133m),
        .sec_133m   (sec_133m),
        .start      (start),
        .unit       (unit),
        .count      (count),
        .cancel     (cancel),
        .busy       (busy),
        .expired    (expired),
        .remaining  (remaining),
        .expire_cnt (expire_cnt)
    );

    typedef struct {
        string       name;
        logic        st;
        logic [1:0]  un;
        logic [15:0] cnt;
        logic        can;
        logic        us, ms, sc;
        logic        e_busy;
        logic        e_exp;
        logic [15:0] e_rem;
        logic [7:0]  e_ec;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string n, input logic st, input logic [1:0] un, input logic [15:0] cnt,
                       input logic can, input logic us, input logic ms, input logic sc,
                       input logic eb, input logic ee, input logic [15:0] er, input logic [7:0] ec);
        vec_t v;
        v.name = n; v.st = st; v.un = un; v.cnt = cnt; v.can = can;
        v.us = us; v.ms = ms; v.sc = sc;
        v.e_busy = eb; v.e_exp = ee; v.e_rem = er; v.e_ec = ec;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic st, input logic [1:0] un, input logic [15:0] cnt,
                         input logic can, input logic us, input logic ms, input logic sc);
        start = st; unit = un; count = cnt; cancel = can;
        usec_133m = us; msec_133m = ms; sec_133m = sc;
    endtask

    // Advance one edge and sample 1 time unit later, away from the edge.
    task automatic step();
        @(posedge clk_133m);
        #1;
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp_v);
        test_cnt++;
        if (act !== exp_v) begin
            fail_cnt++;
            $display("FAIL %s: got %0d, expected %0d", n, act, exp_v);
        end
    endtask

    task automatic chk_all(input string n, input logic eb, input logic ee,
                           input logic [15:0] er, input logic [7:0] ec);
        chk({n, ".busy"},       32'(busy),       32'(eb));
        chk({n, ".expired"},    32'(expired),    32'(ee));
        chk({n, ".remaining"},  32'(remaining),  32'(er));
        chk({n, ".expire_cnt"}, 32'(expire_cnt), 32'(ec));
    endtask

    initial begin
        int exp_ec;
        int rem_exp;

        // ---------------- vector table ----------------
        // unit=3, count=5: busy 5 cycles, then one-cycle expiry.
        add("u3_ld",   1, 3, 5, 0, 0, 0, 0,  1, 0, 5, 0);
        add("u3_t4",   0, 0, 0, 0, 0, 0, 0,  1, 0, 4, 0);
        add("u3_t3",   0, 0, 0, 0, 0, 0, 0,  1, 0, 3, 0);
        add("u3_t2",   0, 0, 0, 0, 0, 0, 0,  1, 0, 2, 0);
        add("u3_t1",   0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0);
        add("u3_fire", 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 1);
        add("u3_idle", 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1);
        // count=0: immediate expiry, never busy.
        add("z_ld",    1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 2);
        add("z_idle",  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2);
        add("idle_can",0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 2);
        // unit=0 count=3: usec on start not counted, msec/sec ignored.
        add("us_ld",   1, 0, 3, 0, 1, 0, 0,  1, 0, 3, 2);
        add("us_ms",   0, 0, 0, 0, 0, 1, 0,  1, 0, 3, 2);
        add("us_sec",  0, 0, 0, 0, 0, 0, 1,  1, 0, 3, 2);
        add("us_t1",   0, 0, 0, 0, 1, 0, 0,  1, 0, 2, 2);
        add("us_t2",   0, 0, 0, 0, 1, 1, 0,  1, 0, 1, 2);
        add("us_none", 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 2);
        add("us_t3",   0, 0, 0, 0, 1, 0, 0,  0, 1, 0, 3);
        add("us_idle", 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 3);
        // unit=1 count=4, cancel after two msec ticks (coincident tick ignored).
        add("ms_ld",   1, 1, 4, 0, 0, 0, 0,  1, 0, 4, 3);
        add("ms_t1",   0, 0, 0, 0, 0, 1, 0,  1, 0, 3, 3);
        add("ms_t2",   0, 0, 0, 0, 0, 1, 0,  1, 0, 2, 3);
        add("ms_can",  0, 0, 0, 1, 0, 1, 0,  0, 0, 0, 3);
        add("ms_idle", 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 3);
        // cancel and start together in RUN: cancel wins.
        add("cs_ld",   1, 3, 9, 0, 0, 0, 0,  1, 0, 9, 3);
        add("cs_both", 1, 3, 2, 1, 0, 0, 0,  0, 0, 0, 3);
        add("cs_idle", 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 3);
        // Restart in RUN with coincident tick.
        add("rs_ld",   1, 1, 10, 0, 0, 0, 0, 1, 0, 10, 3);
        add("rs_t1",   0, 0, 0, 0, 0, 1, 0,  1, 0, 9, 3);
        add("rs_t2",   0, 0, 0, 0, 0, 1, 0,  1, 0, 8, 3);
        add("rs_t3",   0, 0, 0, 0, 0, 1, 0,  1, 0, 7, 3);
        add("rs_rld",  1, 1, 2, 0, 0, 1, 0,  1, 0, 2, 3);
        add("rs_t4",   0, 0, 0, 0, 0, 1, 0,  1, 0, 1, 3);
        add("rs_fire", 0, 0, 0, 0, 0, 1, 0,  0, 1, 0, 4);
        add("rs_idle", 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 4);
        // start during FIRE (cancel ignored there).
        add("fs_z",    1, 3, 0, 0, 0, 0, 0,  0, 1, 0, 5);
        add("fs_ld",   1, 3, 2, 1, 0, 0, 0,  1, 0, 2, 5);
        add("fs_t1",   0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 5);
        add("fs_fire", 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 6);
        add("fs_idle", 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 6);
        // unit=2: only sec counts.
        add("s_ld",    1, 2, 1, 0, 1, 1, 0,  1, 0, 1, 6);
        add("s_us",    0, 0, 0, 0, 1, 1, 0,  1, 0, 1, 6);
        add("s_fire",  0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 7);
        add("s_idle",  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 7);

        // ---------------- reset ----------------
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();
        chk_all("reset", 0, 0, 0, 0);
        rst = 1'b0;
        step();
        chk_all("post_reset", 0, 0, 0, 0);

        // ---------------- table ----------------
        foreach (vecs[i]) begin
            drive(vecs[i].st, vecs[i].un, vecs[i].cnt, vecs[i].can,
                  vecs[i].us, vecs[i].ms, vecs[i].sc);
            step();
            chk_all(vecs[i].name, vecs[i].e_busy, vecs[i].e_exp, vecs[i].e_rem, vecs[i].e_ec);
        end

        // ---------------- usec every 133 cycles ----------------
        drive(1, 0, 3, 0, 0, 0, 0);
        step();
        chk_all("us133_ld", 1, 0, 3, 7);
        for (int s = 1; s <= 3; s++) begin
            rem_exp = 4 - s;
            for (int c = 0; c < 132; c++) begin
                drive(0, 0, 0, 0, 0, (c == 40) ? 1'b1 : 1'b0, (c == 90) ? 1'b1 : 1'b0);
                step();
                if (c == 40 || c == 90 || c == 131) begin
                    chk("us133_hold.rem", 32'(remaining), 32'(rem_exp));
                    chk("us133_hold.exp", 32'(expired), 32'd0);
                end
            end
            drive(0, 0, 0, 0, 1, 0, 0);
            step();
            if (s < 3) begin
                chk_all("us133_tick", 1, 0, 16'(rem_exp - 1), 7);
            end else begin
                chk_all("us133_fire", 0, 1, 0, 8);
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        chk_all("us133_idle", 0, 0, 0, 8);

        // ---------------- reset mid-run ----------------
        drive(1, 3, 50, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (5) step();
        chk_all("mid_run", 1, 0, 45, 8);
        rst = 1'b1;
        drive(1, 3, 0, 0, 1, 1, 1);
        step();
        chk_all("rst_mid", 0, 0, 0, 0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        begin
            int pulses = 0;
            int busies = 0;
            for (int c = 0; c < 60; c++) begin
                step();
                if (expired) pulses++;
                if (busy) busies++;
            end
            chk("rst_no_pulse", 32'(pulses), 32'd0);
            chk("rst_no_busy",  32'(busies), 32'd0);
        end

        // ---------------- saturation: 300 back-to-back zero-count starts ----------------
        drive(1, 3, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 300; k++) begin
            step();
            exp_ec = (k > 255) ? 255 : k;
            chk("sat.expire_cnt", 32'(expire_cnt), 32'(exp_ec));
            chk("sat.expired",    32'(expired),    32'd1);
            chk("sat.busy",       32'(busy),       32'd0);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        chk_all("sat_end", 0, 0, 0, 255);

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
